// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO interconnect.
// Holds the FSM state encoding, the bus-error data pattern and a width helper.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  // Ceiling log2, never less than 1 so it can size a vector directly.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational CPU address decoder: channel 0 below BASE_ADDR, then equal
// power-of-two peripheral windows; anything past the last window is unmapped.
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int                NUM_PER     = 4,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0080,
  parameter int                REGION_LOG2 = 4,
  parameter int                SEL_W       = clog2(NUM_PER)
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_PER-1:0] onehot,
  output logic [ADDR_W-1:0]  offset,
  output logic               mapped
);

  localparam logic [ADDR_W-1:0] MASK     = (ADDR_W'(1) << REGION_LOG2) - ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_WIN = ADDR_W'(NUM_PER - 1);

  logic [ADDR_W-1:0] diff;
  logic [ADDR_W-1:0] win;

  // Window index is compared before adding 1 so the top window cannot wrap.
  always_comb begin
    diff   = addr - BASE_ADDR;
    win    = diff >> REGION_LOG2;
    sel    = '0;
    onehot = '0;
    offset = '0;
    mapped = 1'b0;
    if (addr < BASE_ADDR) begin
      onehot = NUM_PER'(1);
      offset = addr;
      mapped = 1'b1;
    end else if (win < LAST_WIN) begin
      sel    = SEL_W'(win + ADDR_W'(1));
      onehot = NUM_PER'(1) << sel;
      offset = diff & MASK;
      mapped = 1'b1;
    end
  end

endmodule

// File: rtl/mmio_interconnect.sv
// Single-CPU MMIO interconnect: decodes an access onto one of NUM_PER targets with
// a registered request/ready handshake, bus errors for unmapped addresses and timeouts.
module mmio_interconnect
  import mmio_pkg::*;
#(
  parameter int                NUM_PER     = 4,
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0080,
  parameter int                REGION_LOG2 = 4,
  parameter int                TIMEOUT     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_cpu,
  input  logic [ADDR_W-1:0]         addr_cpu,
  input  logic [DATA_W-1:0]         wdata_cpu,
  input  logic [DATA_W/8-1:0]       we_cpu,
  output logic [DATA_W-1:0]         rdata_cpu,
  output logic                      ready_cpu,
  output logic                      err_cpu,
  output logic [NUM_PER-1:0]        ce,
  output logic [ADDR_W-1:0]         addr_per,
  output logic [DATA_W-1:0]         wdata_per,
  output logic [DATA_W/8-1:0]       we_per,
  input  logic [NUM_PER*DATA_W-1:0] rdata_per,
  input  logic [NUM_PER-1:0]        ready_per
);

  localparam int                    SEL_W    = clog2(NUM_PER);
  localparam int                    BE_W     = DATA_W / 8;
  localparam int                    CNT_W    = clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam int                    ERR_REP  = (DATA_W + 31) / 32;
  localparam logic [32*ERR_REP-1:0] ERR_WIDE = {ERR_REP{ERR_DATA}};
  localparam logic [DATA_W-1:0]     ERR_VAL  = ERR_WIDE[DATA_W-1:0];

  state_t state, next_state;

  logic [SEL_W-1:0]   sel_q;
  logic [NUM_PER-1:0] onehot_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [BE_W-1:0]    we_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;

  logic [SEL_W-1:0]   dec_sel;
  logic [NUM_PER-1:0] dec_onehot;
  logic [ADDR_W-1:0]  dec_offset;
  logic               dec_mapped;

  logic               ready_sel;
  logic               timed_out;
  logic [DATA_W-1:0]  rdata_arr [NUM_PER];

  mmio_addr_decode #(
    .NUM_PER     (NUM_PER),
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE_ADDR),
    .REGION_LOG2 (REGION_LOG2),
    .SEL_W       (SEL_W)
  ) u_decode (
    .addr   (addr_cpu),
    .sel    (dec_sel),
    .onehot (dec_onehot),
    .offset (dec_offset),
    .mapped (dec_mapped)
  );

  for (genvar i = 0; i < NUM_PER; i++) begin : g_rdata
    assign rdata_arr[i] = rdata_per[i*DATA_W +: DATA_W];
  end

  assign addr_per  = addr_q;
  assign wdata_per = wdata_q;
  assign rdata_cpu = rdata_q;
  assign err_cpu   = err_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Target strobes exist only in ACCESS, so a reset or response drops them at once.
  always_comb begin
    next_state = state;
    ce         = '0;
    we_per     = '0;
    ready_cpu  = 1'b0;
    ready_sel  = ready_per[sel_q];
    timed_out  = (cnt_q == CNT_LAST);
    case (state)
      IDLE: begin
        if (req_cpu) next_state = dec_mapped ? ACCESS : RESP;
      end
      ACCESS: begin
        ce     = onehot_q;
        we_per = we_q;
        if (ready_sel || timed_out) next_state = RESP;
      end
      RESP: begin
        ready_cpu  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Ready is tested before the timeout so a response on the last allowed cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q    <= '0;
      onehot_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_cpu) begin
            cnt_q <= '0;
            if (dec_mapped) begin
              sel_q    <= dec_sel;
              onehot_q <= dec_onehot;
              addr_q   <= dec_offset;
              wdata_q  <= wdata_cpu;
              we_q     <= we_cpu;
            end else begin
              rdata_q <= ERR_VAL;
              err_q   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (ready_sel) begin
            rdata_q <= (we_q == '0) ? rdata_arr[sel_q] : '0;
            err_q   <= 1'b0;
          end else if (timed_out) begin
            rdata_q <= ERR_VAL;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed scoreboard bench for mmio_interconnect: each access pushes its expected
// strobes, response, latency and ACCESS length; a negedge monitor checks them.
module tb_mmio_interconnect;

  localparam int          NUM_PER = 4;
  localparam int          DATA_W  = 32;
  localparam int          ADDR_W  = 32;
  localparam logic [31:0] BASE    = 32'h0000_0080;

  typedef struct {
    logic [3:0]  ce;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          ce_cycles;
    int          t0;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      req_cpu;
  logic [ADDR_W-1:0]         addr_cpu;
  logic [DATA_W-1:0]         wdata_cpu;
  logic [DATA_W/8-1:0]       we_cpu;
  logic [DATA_W-1:0]         rdata_cpu;
  logic                      ready_cpu;
  logic                      err_cpu;
  logic [NUM_PER-1:0]        ce;
  logic [ADDR_W-1:0]         addr_per;
  logic [DATA_W-1:0]         wdata_per;
  logic [DATA_W/8-1:0]       we_per;
  logic [NUM_PER*DATA_W-1:0] rdata_per;
  logic [NUM_PER-1:0]        ready_per;

  int          wait_cfg [NUM_PER];
  logic [31:0] rd_val [NUM_PER];
  logic [3:0]  ready_force;
  int          acc_cnt = 0;
  int          cyc = 0;
  int          ce_seen = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb [$];

  mmio_interconnect dut (
    .clk       (clk),
    .reset     (reset),
    .req_cpu   (req_cpu),
    .addr_cpu  (addr_cpu),
    .wdata_cpu (wdata_cpu),
    .we_cpu    (we_cpu),
    .rdata_cpu (rdata_cpu),
    .ready_cpu (ready_cpu),
    .err_cpu   (err_cpu),
    .ce        (ce),
    .addr_per  (addr_per),
    .wdata_per (wdata_per),
    .we_per    (we_per),
    .rdata_per (rdata_per),
    .ready_per (ready_per)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    acc_cnt <= (ce == '0) ? 0 : acc_cnt + 1;
  end

  // Target model: channel i answers after wait_cfg[i] wait states (-1 = never).
  always_comb begin
    for (int i = 0; i < NUM_PER; i++) begin
      ready_per[i] = ready_force[i] | (ce[i] && (wait_cfg[i] >= 0) && (acc_cnt == wait_cfg[i]));
      rdata_per[i*DATA_W +: DATA_W] = rd_val[i];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ce !== '0 && sb.size() != 0) begin
      ce_seen++;
      checkOutput("ce", 64'(ce), 64'(sb[0].ce));
      checkOutput("addr_per", 64'(addr_per), 64'(sb[0].addr));
      checkOutput("wdata_per", 64'(wdata_per), 64'(sb[0].wdata));
      checkOutput("we_per", 64'(we_per), 64'(sb[0].we));
    end
    if (ce === '0) checkOutput("we_gate", 64'(we_per), 64'(0));
    if (ready_cpu === 1'b1) begin
      checkOutput("ready_expected", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("rdata_cpu", 64'(rdata_cpu), 64'(e.rdata));
        checkOutput("err_cpu", 64'(err_cpu), 64'(e.err));
        checkOutput("latency", 64'(cyc - e.t0), 64'(e.lat));
        checkOutput("ce_cycles", 64'(ce_seen), 64'(e.ce_cycles));
      end
      ce_seen = 0;
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                               input logic [3:0] exp_ce, input logic [31:0] exp_off,
                               input logic [31:0] exp_rd, input logic exp_err,
                               input int lat, input int n_ce);
    exp_t e;
    @(negedge clk);
    addr_cpu  = a;
    wdata_cpu = wd;
    we_cpu    = we;
    req_cpu   = 1'b1;
    e.ce = exp_ce; e.addr = exp_off; e.wdata = wd; e.we = we;
    e.rdata = exp_rd; e.err = exp_err; e.lat = lat; e.ce_cycles = n_ce; e.t0 = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_cpu   = 1'b0;
    addr_cpu  = $urandom();
    wdata_cpu = $urandom();
    we_cpu    = ~we;
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("done_in_time", 64'(sb.size()), 64'(0));
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; req_cpu = 1'b0; addr_cpu = '0; wdata_cpu = '0; we_cpu = '0;
    ready_force = 4'b0000;
    wait_cfg = '{0, 0, 3, 0};
    rd_val   = '{32'hA5A5_A5A5, 32'hCAFE_0001, 32'h1234_5678, 32'h55AA_33CC};
    repeat (3) @(negedge clk);
    checkOutput("rst_ce", 64'(ce), 64'(0));
    checkOutput("rst_ready", 64'(ready_cpu), 64'(0));
    checkOutput("rst_err", 64'(err_cpu), 64'(0));
    checkOutput("rst_rdata", 64'(rdata_cpu), 64'(0));
    checkOutput("rst_addr_per", 64'(addr_per), 64'(0));
    checkOutput("rst_wdata_per", 64'(wdata_per), 64'(0));
    reset = 1'b0;

    // Writes to channel 1 (zero wait); write responses carry rdata 0.
    applyStimulus(BASE + 4, 32'd1, 4'hF, 4'b0010, 32'h4, 32'h0, 1'b0, 2, 1);
    applyStimulus(BASE + 4, 32'd2, 4'hF, 4'b0010, 32'h4, 32'h0, 1'b0, 2, 1);
    applyStimulus(BASE + 4, 32'd3, 4'hF, 4'b0010, 32'h4, 32'h0, 1'b0, 2, 1);
    applyStimulus(BASE + 8, 32'd9, 4'hF, 4'b0010, 32'h8, 32'h0, 1'b0, 2, 1);

    // Read with three wait states on channel 2, then channel 0 reads.
    applyStimulus(BASE + 28, 32'h0, 4'h0, 4'b0100, 32'hC, 32'h1234_5678, 1'b0, 5, 4);
    applyStimulus(32'h40, 32'h0, 4'h0, 4'b0001, 32'h40, 32'hA5A5_A5A5, 1'b0, 2, 1);
    applyStimulus(32'h7F, 32'h0, 4'h0, 4'b0001, 32'h7F, 32'hA5A5_A5A5, 1'b0, 2, 1);

    // Last byte of the top window, then just past it and a wrapping address.
    applyStimulus(BASE + 47, 32'h0, 4'h0, 4'b1000, 32'hF, 32'h55AA_33CC, 1'b0, 2, 1);
    applyStimulus(BASE + 48, 32'h0, 4'h0, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b1, 1, 0);
    repeat (2) @(negedge clk);
    checkOutput("err_hold", 64'(err_cpu), 64'(1));
    checkOutput("rdata_hold", 64'(rdata_cpu), 64'(32'hDEAD_BEEF));
    applyStimulus(32'hFFFF_FFF0, 32'h0, 4'h0, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b1, 1, 0);

    // Channel 3 never answers while the other channels hold ready high.
    wait_cfg[3] = -1;
    ready_force = 4'b0111;
    applyStimulus(BASE + 32, 32'h0, 4'h0, 4'b1000, 32'h0, 32'hDEAD_BEEF, 1'b1, 17, 16);
    ready_force = 4'b0000;
    wait_cfg[3] = 15;
    applyStimulus(BASE + 32, 32'h0, 4'h0, 4'b1000, 32'h0, 32'h55AA_33CC, 1'b0, 17, 16);

    // Reset on the second wait cycle aborts without a ready pulse.
    wait_cfg[3] = -1;
    @(negedge clk);
    addr_cpu = BASE + 36; we_cpu = 4'h0; req_cpu = 1'b1;
    @(posedge clk);
    #1;
    req_cpu = 1'b0;
    @(negedge clk);
    checkOutput("abort_ce_w1", 64'(ce), 64'(4'b1000));
    @(negedge clk);
    checkOutput("abort_ce_w2", 64'(ce), 64'(4'b1000));
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_ce", 64'(ce), 64'(0));
    checkOutput("abort_ready", 64'(ready_cpu), 64'(0));
    checkOutput("abort_rdata", 64'(rdata_cpu), 64'(0));
    reset = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(BASE + 4, 32'd7, 4'hF, 4'b0010, 32'h4, 32'h0, 1'b0, 2, 1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_interconnect.md
Name: mmio_interconnect

Overview:
- Parametrised successor to the single-CPU, two-target address decoder and read-data select pair.
- Decodes one CPU memory-mapped access onto one of NUM_PER targets. Channel 0 is default memory; channels 1..NUM_PER-1 are peripherals in equal power-of-two windows starting at BASE_ADDR.
- Adds behaviour the old combinational decoder lacks:
  - registered request/ready handshake with wait states;
  - registered read data;
  - bus-error response for out-of-range addresses;
  - timeout for targets that never respond.

Parameters:
- NUM_PER, 4, number of targets including channel 0 (2..16).
- DATA_W, 32, data width; byte enables are DATA_W/8 bits.
- ADDR_W, 32, address width.
- BASE_ADDR, 32'h00000080, base of channel 1; addresses below it go to channel 0.
- REGION_LOG2, 4, log2 of the peripheral window size in bytes (16 B = 4 registers).
- TIMEOUT, 16, maximum ACCESS cycles before a bus error (>=2).

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset, input, 1, synchronous active-high reset.
- req_cpu, input, 1, CPU access request; sampled only in IDLE.
- addr_cpu, input, ADDR_W, CPU byte address.
- wdata_cpu, input, DATA_W, CPU write data.
- we_cpu, input, DATA_W/8, byte write enables; 0 means read.
- rdata_cpu, output, DATA_W, registered read data; valid while ready_cpu=1.
- ready_cpu, output, 1, one-cycle completion pulse.
- err_cpu, output, 1, bus error flag; valid with ready_cpu.
- ce, output, NUM_PER, one-hot target chip enable.
- addr_per, output, ADDR_W, address offset within the selected window (channel 0: full address).
- wdata_per, output, DATA_W, latched write data.
- we_per, output, DATA_W/8, latched byte enables; gated to 0 outside ACCESS.
- rdata_per, input, NUM_PER*DATA_W, flattened target read buses; channel i at bits [i*DATA_W +: DATA_W].
- ready_per, input, NUM_PER, per-target ready; may be high in the first ACCESS cycle (zero wait).

Behaviour:
- Reset: state=IDLE; ce=0, we_per=0, addr_per=0, wdata_per=0, rdata_cpu=0, ready_cpu=0, err_cpu=0, timeout counter=0. Reset mid-transaction aborts immediately; no ready_cpu pulse is issued.
- Decode:
  - addr < BASE_ADDR -> channel 0.
  - Otherwise idx = ((addr-BASE_ADDR)>>REGION_LOG2)+1. idx<NUM_PER -> channel idx; else unmapped.
  - Peripheral offset = (addr-BASE_ADDR) & (2^REGION_LOG2-1).
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If req_cpu=1 and mapped: latch sel, addr_per, wdata_per, we_per; go to ACCESS (ce[sel]=1 from the next cycle).
  - If req_cpu=1 and unmapped: go to RESP with err=1 and rdata=ERR_DATA. No ce is ever asserted.
- ACCESS:
  - ce[sel]=1; all other ce bits are 0.
  - When ready_per[sel]=1: capture rdata_per[sel] into rdata_cpu (reads only; writes load 0), go to RESP.
  - ready_per of unselected channels is ignored.
  - The counter increments each ACCESS cycle. If it reaches TIMEOUT-1 without ready: go to RESP with err=1, rdata=ERR_DATA.
  - ready arriving in the same cycle the counter reaches TIMEOUT-1 wins: normal completion, no error.
- RESP:
  - ready_cpu=1 for exactly one cycle; ce=0, we_per=0; return to IDLE.
  - err_cpu and rdata_cpu hold their values until the next RESP.
- Latency: mapped zero-wait access completes with ready_cpu 2 cycles after req is sampled. Each wait state adds 1 cycle. Unmapped error returns after 1 cycle.
- Back-to-back: req_cpu still high in the IDLE cycle after RESP starts a new transaction. The CPU drops req on the ready_cpu edge to avoid a repeat.
- Input changes on addr/wdata/we_cpu outside IDLE have no effect.
- Width rules: address arithmetic is ADDR_W unsigned with no wrap. Addresses beyond the last window are unmapped, including on overflow of the top window.

Decomposition:
- mmio_pkg holds:
  - state enum {IDLE, ACCESS, RESP};
  - ERR_DATA = 32'hDEAD_BEEF (replicated or truncated to DATA_W);
  - localparam function clog2 for the timeout counter width.
- Sub-module mmio_addr_decode: purely combinational. Maps addr_cpu to {sel index, one-hot, offset, mapped flag}; reused by future multi-master variants.

Test Plan:
- Write sequence: BASE+4 with data 1,2,3 (we=4'hF), then BASE+8 data 9; ch1 ready tied high -> each access has ce=4'b0010, addr_per=4 (then 8), ready_cpu 2 cycles after req, err=0.
- Read with wait states: addr BASE+16+12, ch2 ready after 3 cycles, rdata_per ch2=32'h12345678 -> ce=4'b0100 for 4 cycles, ready_cpu at cycle 5, rdata_cpu=32'h12345678.
- Channel 0: addr 32'h40 read, ch0 data 32'hA5A5A5A5 -> ce=4'b0001, addr_per=32'h40, rdata_cpu=32'hA5A5A5A5.
- Unmapped: addr BASE+48 (NUM_PER=4) -> ce stays 0, ready_cpu next cycle, err_cpu=1, rdata_cpu=32'hDEADBEEF.
- Timeout: ch3 ready never asserted -> ce[3] high for exactly 16 cycles, then ready_cpu with err_cpu=1. Also ready asserted exactly on cycle 16 -> err_cpu=0.
- Reset during ACCESS: pulse reset on the 2nd wait cycle -> next cycle ce=0, ready_cpu=0, state IDLE. A following BASE+4 write completes normally.
